// File: rtl/sr_sequencer_if.sv
// rtl/sr_sequencer_if.sv - command handshake bundle for sr_sequencer
interface sr_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/sr_sequencer.sv
// rtl/sr_sequencer.sv - command-driven controller for a 4-bit universal shift register
// Optional macro SR_SEQ_ROTATE_EN: op 11 rotates right; otherwise op 11 completes with no shift.
module sr_sequencer (
  input  logic               clk,
  input  logic               clear,
  sr_sequencer_if.slave      cmd,
  input  logic [3:0]         A_in,
  output logic [3:0]         I,
  output logic [1:0]         s,
  output logic               SIL,
  output logic               SIR,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

`ifdef SR_SEQ_ROTATE_EN
  localparam bit rotate_en = 1'b1;
`else
  localparam bit rotate_en = 1'b0;
`endif

  state_t     state;
  logic [1:0] op_q;
  logic [2:0] cnt;
  logic       sil_q;
  logic       sir_q;
  logic       shift_ok;

  assign cmd.cmd_ready = (state == IDLE);

  // A shift op only reaches SHIFT with a nonzero count; op 11 also needs rotate support.
  assign shift_ok = (cmd.cmd_count != 3'd0) && ((cmd.cmd_op != 2'b11) || rotate_en);

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      op_q  <= 2'b00;
      cnt   <= 3'd0;
      s     <= 2'b11;
      I     <= 4'b0000;
      sil_q <= 1'b0;
      sir_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            op_q <= cmd.cmd_op;
            cnt  <= cmd.cmd_count;
            if (cmd.cmd_op == 2'b00) begin
              state <= LOAD;
              s     <= 2'b00;
              I     <= cmd.cmd_data;
            end else if (shift_ok) begin
              state <= SHIFT;
              s     <= (cmd.cmd_op == 2'b10) ? 2'b10 : 2'b01;
              sil_q <= (cmd.cmd_op == 2'b01) && cmd.cmd_fill;
              sir_q <= (cmd.cmd_op == 2'b10) && cmd.cmd_fill;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          state <= DONE;
          s     <= 2'b11;
          done  <= 1'b1;
        end
        SHIFT: begin
          if (cnt == 3'd1) begin
            state <= DONE;
            s     <= 2'b11;
            sil_q <= 1'b0;
            sir_q <= 1'b0;
            done  <= 1'b1;
          end
          cnt <= cnt - 3'd1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          s     <= 2'b11;
        end
      endcase
    end
  end

  assign SIR = sir_q;

`ifdef SR_SEQ_ROTATE_EN
  // Rotate feeds the current LSB straight back into the MSB each shift cycle.
  assign SIL = ((state == SHIFT) && (op_q == 2'b11)) ? A_in[0] : sil_q;
  logic unused_a_hi;
  assign unused_a_hi = ^A_in[3:1];
`else
  assign SIL = sil_q;
  logic unused_feedback;
  assign unused_feedback = ^{A_in, op_q};
`endif

endmodule

// File: tb/tb_sr_sequencer.sv
// tb/tb_sr_sequencer.sv - directed self-checking bench for sr_sequencer driving a model shift register
module tb_sr_sequencer;
  logic       clk;
  logic       clear;
  logic [3:0] a_reg;
  logic [3:0] i_out;
  logic [1:0] s_out;
  logic       sil;
  logic       sir;
  logic       done;
  int         checks;
  int         failures;

  sr_sequencer_if cmd_if ();

  sr_sequencer dut (
    .clk   (clk),
    .clear (clear),
    .cmd   (cmd_if),
    .A_in  (a_reg),
    .I     (i_out),
    .s     (s_out),
    .SIL   (sil),
    .SIR   (sir),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached universal shift register driven by the sequencer outputs.
  always @(posedge clk) begin
    case (s_out)
      2'b00:   a_reg <= i_out;
      2'b01:   a_reg <= {sil, a_reg[3:1]};
      2'b10:   a_reg <= {a_reg[2:0], sir};
      default: a_reg <= a_reg;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int op, input int data, input int cnt, input int fill);
    cmd_if.cmd_op    = 2'(op);
    cmd_if.cmd_data  = 4'(data);
    cmd_if.cmd_count = 3'(cnt);
    cmd_if.cmd_fill  = 1'(fill);
    cmd_if.cmd_valid = 1'b1;
    chk("ready_at_accept", 32'(cmd_if.cmd_ready), 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = ~cmd_if.cmd_data;
    cmd_if.cmd_count = ~cmd_if.cmd_count;
    cmd_if.cmd_fill  = ~cmd_if.cmd_fill;
  endtask

  task automatic do_load(input int data);
    issue(0, data, 0, 0);
    chk("load_s", 32'(s_out), 32'd0);
    chk("load_i", 32'(i_out), 32'(data));
    chk("load_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("load_done_low", 32'(done), 32'd0);
    tick();
    chk("load_end_s", 32'(s_out), 32'd3);
    chk("load_done", 32'(done), 32'd1);
    chk("load_a", 32'(a_reg), 32'(data));
    chk("load_i_hold", 32'(i_out), 32'(data));
    tick();
    chk("load_done_clr", 32'(done), 32'd0);
    chk("load_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
  endtask

  task automatic run_shift(input int op, input int cnt, input int fill, input int exp_s, input int exp_a);
    issue(op, 0, cnt, fill);
    for (int k = 0; k < cnt; k++) begin
      chk("shift_s", 32'(s_out), 32'(exp_s));
      chk("shift_done_low", 32'(done), 32'd0);
      if (op == 1) chk("shift_sil", 32'(sil), 32'(fill));
      else if (op == 3) chk("rot_sil", 32'(sil), 32'(a_reg[0]));
      else chk("shift_sil_zero", 32'(sil), 32'd0);
      chk("shift_sir", 32'(sir), (op == 2) ? 32'(fill) : 32'd0);
      tick();
    end
    chk("shift_end_s", 32'(s_out), 32'd3);
    chk("shift_done", 32'(done), 32'd1);
    chk("shift_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    chk("shift_end_sil", 32'(sil), 32'd0);
    chk("shift_end_sir", 32'(sir), 32'd0);
    chk("shift_a", 32'(a_reg), 32'(exp_a));
    tick();
    chk("shift_done_clr", 32'(done), 32'd0);
    chk("shift_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
    chk("shift_a_hold", 32'(a_reg), 32'(exp_a));
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    a_reg            = 4'b0000;
    clear            = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_data  = 4'b0000;
    cmd_if.cmd_count = 3'd0;
    cmd_if.cmd_fill  = 1'b0;

    repeat (2) tick();
    clear = 1'b0;
    chk("rst_s", 32'(s_out), 32'd3);
    chk("rst_i", 32'(i_out), 32'd0);
    chk("rst_sil", 32'(sil), 32'd0);
    chk("rst_sir", 32'(sir), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    tick();

    do_load(4'b1011);
    run_shift(1, 2, 1, 1, 4'b1110);
    run_shift(2, 3, 0, 2, 4'b0000);

    issue(2, 0, 0, 1);
    chk("zero_cnt_s", 32'(s_out), 32'd3);
    chk("zero_cnt_done", 32'(done), 32'd1);
    chk("zero_cnt_ready", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    chk("zero_cnt_done_clr", 32'(done), 32'd0);
    chk("zero_cnt_a", 32'(a_reg), 32'd0);

    do_load(4'b1100);
`ifdef SR_SEQ_ROTATE_EN
    run_shift(3, 2, 0, 1, 4'b0011);
`else
    issue(3, 0, 2, 0);
    chk("norot_s", 32'(s_out), 32'd3);
    chk("norot_done", 32'(done), 32'd1);
    tick();
    chk("norot_done_clr", 32'(done), 32'd0);
    chk("norot_a", 32'(a_reg), 32'b1100);
`endif

    issue(1, 0, 7, 0);
    repeat (3) begin
      chk("abort_s", 32'(s_out), 32'd1);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_s_idle", 32'(s_out), 32'd3);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("abort_i", 32'(i_out), 32'd0);
    chk("abort_sil", 32'(sil), 32'd0);
    repeat (3) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_s_hold", 32'(s_out), 32'd3);
    end

    do_load(4'b0110);
    run_shift(1, 1, 0, 1, 4'b0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
